// File: rtl/mem_responder.sv
// Fixed-latency memory-side responder for the 16-bit core memory port.
// Word-addressed backing array with byte-enable writes and a sticky protocol-violation flag.
module mem_responder #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        proto_err,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic [1:0]             be_q, be_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   resp_q, resp_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [DEPTH_LOG2-1:0]  req_idx;
    logic [15:0]            mem_q [DEPTH];

    // Address bits outside the word index alias onto the same array.
    logic unused_addr;
    assign unused_addr = ^{mem_address[15:DEPTH_LOG2+1], mem_address[0]};

    assign req_idx = mem_address[DEPTH_LOG2:1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    wr_d    = mem_write;
                    idx_d   = req_idx;
                    be_d    = mem_byte_enable;
                    wdata_d = mem_wdata;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (!mem_read && !mem_write) begin
                    state_d = IDLE;
                end else begin
                    // Initiator must hold the request stable; latched values stay in use.
                    if ((mem_write != wr_q) || (mem_read == wr_q) || (req_idx != idx_q) ||
                        (wr_q && (mem_wdata != wdata_q))) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Read data is captured on entry to RESP so it is a clean register output.
        if ((state_d == RESP) && !wr_d) begin
            rdata_d = mem_q[idx_d];
        end
    end

    assign resp_d = (state_d == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            be_q    <= 2'b00;
            wdata_q <= 16'h0000;
            resp_q  <= 1'b0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset forces state_q to IDLE asynchronously, which discards an in-flight write.
    always_ff @(posedge clk) begin
        if ((state_q == RESP) && wr_q) begin
            if (be_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
            if (be_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
        end
    end

    assign mem_resp    = resp_q;
    assign mem_rdata   = rdata_q;
    assign proto_err   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: one instance at LATENCY=3, one at LATENCY=1.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        rd_i    [2];
  logic        wr_i    [2];
  logic [1:0]  be_i    [2];
  logic [15:0] addr_i  [2];
  logic [15:0] wdata_i [2];
  logic        resp_o  [2];
  logic [15:0] rdata_o [2];
  logic        err_o   [2];
  logic [1:0]  st_o    [2];

  int checks = 0;
  int errors = 0;

  // Reference memory image per instance, indexed by word.
  logic [15:0] model_mem [2][256];
  // Expected responses: bit16 = read, [15:0] = expected read data.
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  logic [16:0] e0, e1;

  mem_responder #(.LATENCY(3), .DEPTH_LOG2(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_i[0]), .mem_write(wr_i[0]),
    .mem_byte_enable(be_i[0]), .mem_address(addr_i[0]), .mem_wdata(wdata_i[0]),
    .mem_resp(resp_o[0]), .mem_rdata(rdata_o[0]), .proto_err(err_o[0]),
    .dbg_state_o(st_o[0])
  );

  mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_i[1]), .mem_write(wr_i[1]),
    .mem_byte_enable(be_i[1]), .mem_address(addr_i[1]), .mem_wdata(wdata_i[1]),
    .mem_resp(resp_o[1]), .mem_rdata(rdata_o[1]), .proto_err(err_o[1]),
    .dbg_state_o(st_o[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (resp_o[0] === 1'b1) begin
      check("resp0_expected", 32'(exp_q0.size() != 0), 32'd1);
      if (exp_q0.size() != 0) begin
        e0 = exp_q0.pop_front();
        if (e0[16]) check("rdata0", 32'(rdata_o[0]), 32'(e0[15:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (resp_o[1] === 1'b1) begin
      check("resp1_expected", 32'(exp_q1.size() != 0), 32'd1);
      if (exp_q1.size() != 0) begin
        e1 = exp_q1.pop_front();
        if (e1[16]) check("rdata1", 32'(rdata_o[1]), 32'(e1[15:0]));
      end
    end
  end

  // driver tasks
  task automatic push_expect(input int u, input bit is_wr, input logic [15:0] addr,
                             input logic [15:0] data, input logic [1:0] be);
    int idx;
    logic [16:0] e;
    idx = (int'(addr) / 2) % 256;
    e = is_wr ? 17'h0 : {1'b1, model_mem[u][idx]};
    if (u == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    if (is_wr) begin
      for (int b = 0; b < 2; b++)
        if (be[b]) model_mem[u][idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic drive_req(input int u, input bit is_wr, input logic [15:0] addr,
                           input logic [15:0] data, input logic [1:0] be);
    rd_i[u]    = !is_wr;
    wr_i[u]    = is_wr;
    addr_i[u]  = addr;
    wdata_i[u] = data;
    be_i[u]    = be;
  endtask

  task automatic idle_req(input int u);
    rd_i[u] = 1'b0;
    wr_i[u] = 1'b0;
  endtask

  // Full transaction; optionally moves the address in the first wait cycle.
  task automatic txn(input int u, input bit is_wr, input logic [15:0] addr,
                     input logic [15:0] data, input logic [1:0] be,
                     input bit chg, input logic [15:0] chg_addr);
    int lat;
    lat = (u == 0) ? 3 : 1;
    @(posedge clk); #1;
    drive_req(u, is_wr, addr, data, be);
    push_expect(u, is_wr, addr, data, be);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (chg && c == 1) addr_i[u] = chg_addr;
      if (c < lat) check("resp_early", 32'(resp_o[u]), 32'd0);
      else         check("resp_on_time", 32'(resp_o[u]), 32'd1);
    end
    idle_req(u);
  endtask

  task automatic wr(input int u, input logic [15:0] addr, input logic [15:0] data,
                    input logic [1:0] be);
    txn(u, 1'b1, addr, data, be, 1'b0, 16'h0);
  endtask

  task automatic rd(input int u, input logic [15:0] addr);
    txn(u, 1'b0, addr, 16'h0, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) idle_req(u);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // main stimulus
  initial begin
    for (int u = 0; u < 2; u++) begin
      idle_req(u);
      addr_i[u] = 16'h0; wdata_i[u] = 16'h0; be_i[u] = 2'b00;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("reset_resp", 32'(resp_o[u]), 32'd0);
      check("reset_rdata", 32'(rdata_o[u]), 32'd0);
      check("reset_err", 32'(err_o[u]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Give every word a defined value so any random read has a known answer.
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 256; i++)
        wr(u, 16'(i * 2), 16'($urandom_range(0, 65535)), 2'b11);

    // Write then read
    wr(0, 16'h0010, 16'hBEEF, 2'b11);
    rd(0, 16'h0010);
    // Byte masks, including odd byte address of the same word
    wr(0, 16'h0020, 16'h1234, 2'b11);
    wr(0, 16'h0020, 16'hAB00, 2'b10);
    wr(0, 16'h0020, 16'h00CD, 2'b01);
    wr(0, 16'h0020, 16'hFFFF, 2'b00);
    rd(0, 16'h0020);
    rd(0, 16'h0021);
    check("err_clean", 32'(err_o[0]), 32'd0);

    // Aliasing and back-to-back on the LATENCY=1 instance
    wr(1, 16'h0002, 16'h5555, 2'b11);
    rd(1, 16'h0202);
    rd(1, 16'h8002);

    // Abort: drop the write after one wait cycle
    wr(0, 16'h0030, 16'h1111, 2'b11);
    @(posedge clk); #1;
    drive_req(0, 1'b1, 16'h0030, 16'h2222, 2'b11);
    @(posedge clk); #1;
    check("abort_no_resp", 32'(resp_o[0]), 32'd0);
    @(posedge clk); #1;
    idle_req(0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("abort_no_resp", 32'(resp_o[0]), 32'd0);
    end
    rd(0, 16'h0030);

    // Both read and write high in IDLE
    @(posedge clk); #1;
    drive_req(0, 1'b1, 16'h0050, 16'h4242, 2'b11);
    rd_i[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("both_no_resp", 32'(resp_o[0]), 32'd0);
      check("both_err", 32'(err_o[0]), 32'd1);
    end
    idle_req(0);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", 32'(err_o[0]), 32'd1);
    apply_reset();
    #1;
    check("err_cleared", 32'(err_o[0]), 32'd0);

    // Address moved mid-wait: data comes from the originally latched word
    wr(0, 16'h0060, 16'hC0DE, 2'b11);
    wr(0, 16'h0070, 16'hFACE, 2'b11);
    txn(0, 1'b0, 16'h0060, 16'h0, 2'b00, 1'b1, 16'h0070);
    check("addr_change_err", 32'(err_o[0]), 32'd1);

    // Reset during the wait of a write
    wr(0, 16'h0040, 16'h7777, 2'b11);
    @(posedge clk); #1;
    drive_req(0, 1'b1, 16'h0040, 16'h9999, 2'b11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_resp", 32'(resp_o[0]), 32'd0);
    check("rst_err", 32'(err_o[0]), 32'd0);
    idle_req(0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_hold_resp", 32'(resp_o[0]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd(0, 16'h0040);

    // Randomized traffic on both instances
    for (int n = 0; n < 80; n++) begin
      for (int u = 0; u < 2; u++) begin
        txn(u, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)), 1'b0, 16'h0);
      end
    end
    for (int u = 0; u < 2; u++) check("random_no_err", 32'(err_o[u]), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("queue0_drained", 32'(exp_q0.size()), 32'd0);
    check("queue1_drained", 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
